// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Brief    : Shared AXI encodings and initiator state type.
// Revision : 1.0
// ============================================================================
package bus_pkg;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    localparam logic [2:0] c_SIZE_4B     = 3'b010;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;
    localparam logic [7:0] c_LEN_1BEAT   = 8'd0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == c_RESP_SLVERR) || (resp == c_RESP_DECERR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : axi_timeout_ctr
// Brief    : Response-wait counter; expired flags the last allowed wait cycle.
// Revision : 1.0
// ============================================================================
module axi_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_clr) begin
            w_cnt_d = '0;
        end else if (i_en && (r_cnt_q != c_LAST)) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_expired = i_en && (r_cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/axi_lite_initiator.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_initiator
// Brief    : Single-outstanding CPU-to-AXI4 bridge with bus-error reporting.
// Revision : 1.0
// ============================================================================
module axi_lite_initiator
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] bad_addr,
    output logic        bad_addr_valid,
    input  logic        bad_addr_ack,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    input  logic [1:0]  m_axi_bresp,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast
);

    state_e      r_state_q, w_state_d;
    logic        r_write_q, w_write_d;
    logic [31:0] r_addr_q, w_addr_d;
    logic [31:0] r_wdata_q, w_wdata_d;
    logic [3:0]  r_wstrb_q, w_wstrb_d;
    logic        r_aw_done_q, w_aw_done_d;
    logic        r_w_done_q, w_w_done_d;
    logic        r_stale_q, w_stale_d;
    logic        r_awvalid_q, w_awvalid_d;
    logic        r_wvalid_q, w_wvalid_d;
    logic        r_bready_q, w_bready_d;
    logic        r_arvalid_q, w_arvalid_d;
    logic        r_rready_q, w_rready_d;
    logic        r_req_ready_q, w_req_ready_d;
    logic        r_rsp_valid_q, w_rsp_valid_d;
    logic [31:0] r_rsp_rdata_q, w_rsp_rdata_d;
    logic        r_rsp_error_q, w_rsp_error_d;
    logic [31:0] r_bad_addr_q, w_bad_addr_d;
    logic        r_bad_valid_q, w_bad_valid_d;

    logic w_wait;
    logic w_expired;
    logic w_resp_err;
    logic w_unused;

    assign w_wait   = (r_state_q == ST_WRESP) || (r_state_q == ST_RDATA);
    assign w_unused = ^{m_axi_rlast, req_addr[1:0]};

    axi_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (!w_wait),
        .i_en      (w_wait),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_write_d     = r_write_q;
        w_addr_d      = r_addr_q;
        w_wdata_d     = r_wdata_q;
        w_wstrb_d     = r_wstrb_q;
        w_aw_done_d   = r_aw_done_q;
        w_w_done_d    = r_w_done_q;
        w_stale_d     = r_stale_q;
        w_bad_addr_d  = r_bad_addr_q;
        w_bad_valid_d = r_bad_valid_q;
        w_rsp_valid_d = 1'b0;
        w_rsp_error_d = 1'b0;
        w_rsp_rdata_d = '0;
        w_resp_err    = 1'b0;

        if (r_bad_valid_q && bad_addr_ack) begin
            w_bad_valid_d = 1'b0;
        end

        case (r_state_q)
            ST_IDLE: begin
                // A late beat from a timed-out transaction is swallowed here.
                if (r_stale_q) begin
                    if (r_write_q ? (m_axi_bvalid && r_bready_q)
                                  : (m_axi_rvalid && r_rready_q)) begin
                        w_stale_d = 1'b0;
                    end
                end else if (req_valid && r_req_ready_q) begin
                    w_write_d   = req_write;
                    w_addr_d    = {req_addr[31:2], 2'b00};
                    w_wdata_d   = req_wdata;
                    w_wstrb_d   = req_wstrb;
                    w_aw_done_d = 1'b0;
                    w_w_done_d  = 1'b0;
                    w_state_d   = req_write ? ST_WADDR : ST_RADDR;
                end
            end
            ST_WADDR: begin
                if (r_awvalid_q && m_axi_awready) w_aw_done_d = 1'b1;
                if (r_wvalid_q && m_axi_wready)   w_w_done_d  = 1'b1;
                if (w_aw_done_d && w_w_done_d)    w_state_d   = ST_WRESP;
            end
            ST_WRESP: begin
                if (m_axi_bvalid) begin
                    w_resp_err    = resp_is_err(m_axi_bresp);
                    w_state_d     = ST_DONE;
                    w_rsp_valid_d = 1'b1;
                end else if (w_expired) begin
                    w_resp_err    = 1'b1;
                    w_stale_d     = 1'b1;
                    w_state_d     = ST_DONE;
                    w_rsp_valid_d = 1'b1;
                end
            end
            ST_RADDR: begin
                if (r_arvalid_q && m_axi_arready) w_state_d = ST_RDATA;
            end
            ST_RDATA: begin
                if (m_axi_rvalid) begin
                    w_resp_err    = resp_is_err(m_axi_rresp);
                    w_rsp_rdata_d = w_resp_err ? 32'h0 : m_axi_rdata;
                    w_state_d     = ST_DONE;
                    w_rsp_valid_d = 1'b1;
                end else if (w_expired) begin
                    w_resp_err    = 1'b1;
                    w_stale_d     = 1'b1;
                    w_state_d     = ST_DONE;
                    w_rsp_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        if (w_rsp_valid_d) begin
            w_rsp_error_d = w_resp_err;
            if (w_resp_err) begin
                w_bad_addr_d  = r_addr_q;
                w_bad_valid_d = 1'b1;
            end
        end

        // Handshake outputs are registered from the next-state view.
        w_awvalid_d   = (w_state_d == ST_WADDR) && !w_aw_done_d;
        w_wvalid_d    = (w_state_d == ST_WADDR) && !w_w_done_d;
        w_arvalid_d   = (w_state_d == ST_RADDR);
        w_bready_d    = (w_state_d == ST_WRESP) ||
                        ((w_state_d == ST_IDLE) && w_stale_d && w_write_d);
        w_rready_d    = (w_state_d == ST_RDATA) ||
                        ((w_state_d == ST_IDLE) && w_stale_d && !w_write_d);
        w_req_ready_d = (w_state_d == ST_IDLE) && !w_stale_d && !w_bad_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_write_q     <= 1'b0;
            r_addr_q      <= '0;
            r_wdata_q     <= '0;
            r_wstrb_q     <= '0;
            r_aw_done_q   <= 1'b0;
            r_w_done_q    <= 1'b0;
            r_stale_q     <= 1'b0;
            r_awvalid_q   <= 1'b0;
            r_wvalid_q    <= 1'b0;
            r_bready_q    <= 1'b0;
            r_arvalid_q   <= 1'b0;
            r_rready_q    <= 1'b0;
            r_req_ready_q <= 1'b0;
            r_rsp_valid_q <= 1'b0;
            r_rsp_rdata_q <= '0;
            r_rsp_error_q <= 1'b0;
            r_bad_addr_q  <= '0;
            r_bad_valid_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_write_q     <= w_write_d;
            r_addr_q      <= w_addr_d;
            r_wdata_q     <= w_wdata_d;
            r_wstrb_q     <= w_wstrb_d;
            r_aw_done_q   <= w_aw_done_d;
            r_w_done_q    <= w_w_done_d;
            r_stale_q     <= w_stale_d;
            r_awvalid_q   <= w_awvalid_d;
            r_wvalid_q    <= w_wvalid_d;
            r_bready_q    <= w_bready_d;
            r_arvalid_q   <= w_arvalid_d;
            r_rready_q    <= w_rready_d;
            r_req_ready_q <= w_req_ready_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_rdata_q <= w_rsp_rdata_d;
            r_rsp_error_q <= w_rsp_error_d;
            r_bad_addr_q  <= w_bad_addr_d;
            r_bad_valid_q <= w_bad_valid_d;
        end
    end

    assign req_ready      = r_req_ready_q;
    assign rsp_valid      = r_rsp_valid_q;
    assign rsp_rdata      = r_rsp_rdata_q;
    assign rsp_error      = r_rsp_error_q;
    assign bad_addr       = r_bad_addr_q;
    assign bad_addr_valid = r_bad_valid_q;

    assign m_axi_awvalid  = r_awvalid_q;
    assign m_axi_awaddr   = r_addr_q;
    assign m_axi_awlen    = c_LEN_1BEAT;
    assign m_axi_awsize   = c_SIZE_4B;
    assign m_axi_awburst  = c_BURST_INCR;
    assign m_axi_wvalid   = r_wvalid_q;
    assign m_axi_wdata    = r_wdata_q;
    assign m_axi_wstrb    = r_wstrb_q;
    assign m_axi_wlast    = 1'b1;
    assign m_axi_bready   = r_bready_q;
    assign m_axi_arvalid  = r_arvalid_q;
    assign m_axi_araddr   = r_addr_q;
    assign m_axi_arlen    = c_LEN_1BEAT;
    assign m_axi_arsize   = c_SIZE_4B;
    assign m_axi_arburst  = c_BURST_INCR;
    assign m_axi_rready   = r_rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_initiator
// Brief    : Vector table plus randomized transactions against a response model.
// Revision : 1.0
// ============================================================================
module tb_axi_lite_initiator;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata, bad_addr;
    logic        bad_addr_valid, bad_addr_ack;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        arvalid, arready, rvalid, rready, rlast;

    always #5 clk = ~clk;

    axi_lite_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .bad_addr(bad_addr), .bad_addr_valid(bad_addr_valid), .bad_addr_ack(bad_addr_ack),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
        .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
        .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
        .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
        .m_axi_rresp(rresp), .m_axi_rlast(rlast)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly;   // address ready delay (AW or AR)
        int          w_dly;
        int          rsp_dly;  // cycles in the wait state before B/R valid
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          ack_dly;  // cycles after completion before bad_addr_ack
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [3:0] ws, input int awd, input int wd_dly,
                                input int rd, input logic [1:0] resp, input logic [31:0] rdat,
                                input int ackd, input bit eerr, input logic [31:0] erd);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wd; v.wstrb = ws;
        v.aw_dly = awd; v.w_dly = wd_dly; v.rsp_dly = rd; v.resp = resp;
        v.rdata = rdat; v.ack_dly = ackd; v.exp_err = eerr; v.exp_rdata = erd;
        return v;
    endfunction

    // Outcome from the bus rules: error responses or no answer within TO cycles fail.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        r = v;
        r.exp_err   = (v.rsp_dly >= TO) || (v.resp == 2'b10) || (v.resp == 2'b11);
        r.exp_rdata = (!v.wr && !r.exp_err) ? v.rdata : 32'h0;
        return r;
    endfunction

    task automatic run(input vec_t v, input string tag);
        int n, k, lat, ack_at, jend, max_dly;
        bit to, a_done, w_done, hs_a, hs_w, consumed, hs_r;
        bit hold_bad, rdy_bad, pulse_bad, bav_bad, rr_bad, exp_rdy, exp_bav, exp_rr;
        logic rdy, other, got_err, got_bav;
        logic [31:0] got_rdata, got_ba;

        to      = (v.rsp_dly >= TO);
        lat     = to ? TO : v.rsp_dly + 1;
        ack_at  = lat + v.ack_dly;
        got_err = 1'bx; got_bav = 1'bx; got_rdata = 'x; got_ba = 'x;

        @(negedge clk);
        req_valid = 1'b1; req_write = v.wr; req_addr = v.addr;
        req_wdata = v.wdata; req_wstrb = v.wstrb;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/accept"}, 32'(req_ready), 32'd1);
        if (req_ready !== 1'b1) begin
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = ~v.wr;

        k = 0; hold_bad = 0; a_done = 0; w_done = !v.wr;
        if (v.wr) begin
            chk({tag, "/aw_w_valid"}, {30'd0, awvalid, wvalid}, 32'd3);
            chk({tag, "/awaddr"}, awaddr, v.addr & ~32'h3);
            chk({tag, "/wdata"}, wdata, v.wdata);
            chk({tag, "/wstrb"}, 32'(wstrb), 32'(v.wstrb));
            chk({tag, "/aw_const"}, {18'd0, awlen, awsize, awburst, wlast}, {18'd0, 8'd0, 3'd2, 2'd1, 1'b1});
        end else begin
            chk({tag, "/arvalid"}, 32'(arvalid), 32'd1);
            chk({tag, "/araddr"}, araddr, v.addr & ~32'h3);
            chk({tag, "/ar_const"}, {19'd0, arlen, arsize, arburst}, {19'd0, 8'd0, 3'd2, 2'd1});
        end
        while (!(a_done && w_done) && k < 50) begin
            if (v.wr) begin
                awready = !a_done && (k >= v.aw_dly);
                wready  = !w_done && (k >= v.w_dly);
                if (awvalid !== !a_done || wvalid !== !w_done) hold_bad = 1;
                hs_a = awvalid && awready;
                hs_w = wvalid && wready;
            end else begin
                arready = (k >= v.aw_dly);
                if (arvalid !== 1'b1) hold_bad = 1;
                hs_a = arvalid && arready;
                hs_w = 0;
            end
            @(negedge clk);
            k++;
            if (hs_a) a_done = 1;
            if (hs_w) w_done = 1;
        end
        awready = 0; wready = 0; arready = 0;
        max_dly = v.wr ? ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) : v.aw_dly;
        chk({tag, "/addr_hold"}, 32'(hold_bad), 32'd0);
        chk({tag, "/addr_cycles"}, k, max_dly + 1);
        chk({tag, "/addr_drop"}, {29'd0, awvalid, wvalid, arvalid}, 32'd0);

        jend = ((v.rsp_dly > ack_at) ? v.rsp_dly : ack_at) + 3;
        consumed = 0; rdy_bad = 0; pulse_bad = 0; bav_bad = 0; rr_bad = 0;
        for (int j = 0; j <= jend; j++) begin
            if (v.wr) begin
                bvalid = !consumed && (j >= v.rsp_dly);
                bresp  = v.resp;
            end else begin
                rvalid = !consumed && (j >= v.rsp_dly);
                rresp  = v.resp;
                rdata  = v.rdata;
                rlast  = 1'b1;
            end
            bad_addr_ack = (j == ack_at);
            rdy   = v.wr ? bready : rready;
            other = v.wr ? rready : bready;
            exp_rdy = to ? ((j < TO) || (j > TO && j <= v.rsp_dly)) : (j <= v.rsp_dly);
            if (rdy !== exp_rdy || other !== 1'b0) rdy_bad = 1;
            if (rsp_valid !== (j == lat)) pulse_bad = 1;
            if (j == lat) begin
                got_err = rsp_error; got_rdata = rsp_rdata;
                got_bav = bad_addr_valid; got_ba = bad_addr;
            end
            exp_bav = v.exp_err && (j >= lat) && (j <= ack_at);
            if (bad_addr_valid !== exp_bav) bav_bad = 1;
            exp_rr = (j > lat) && !(v.exp_err && j <= ack_at) && !(to && j <= v.rsp_dly);
            if (req_ready !== exp_rr) rr_bad = 1;
            hs_r = v.wr ? (bvalid && bready) : (rvalid && rready);
            @(negedge clk);
            if (hs_r) consumed = 1;
        end
        bvalid = 0; rvalid = 0; bad_addr_ack = 0;

        chk({tag, "/beat_consumed"}, 32'(consumed), 32'd1);
        chk({tag, "/ready_seq"}, 32'(rdy_bad), 32'd0);
        chk({tag, "/rsp_pulse"}, 32'(pulse_bad), 32'd0);
        chk({tag, "/rsp_error"}, 32'(got_err), 32'(v.exp_err));
        chk({tag, "/rsp_rdata"}, got_rdata, v.exp_rdata);
        chk({tag, "/bad_valid_at_done"}, 32'(got_bav), 32'(v.exp_err));
        chk({tag, "/bad_valid_seq"}, 32'(bav_bad), 32'd0);
        chk({tag, "/req_ready_seq"}, 32'(rr_bad), 32'd0);
        if (v.exp_err) begin
            chk({tag, "/bad_addr_done"}, got_ba, v.addr & ~32'h3);
            chk({tag, "/bad_addr_held"}, bad_addr, v.addr & ~32'h3);
        end
    endtask

    vec_t tbl[10];

    initial begin
        rst = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        bad_addr_ack = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;

        tbl[0] = mk(0, 32'hF803_0014, 0, 0, 0, 0, 0, 2'b00, 32'h0000_0007, 1, 0, 32'h0000_0007);
        tbl[1] = mk(1, 32'hF803_0000, 32'hFFFF_0000, 4'hF, 0, 3, 0, 2'b00, 0, 1, 0, 32'h0);
        tbl[2] = mk(0, 32'hF803_00F0, 0, 0, 1, 0, 1, 2'b10, 32'hDEAD_BEEF, 5, 1, 32'h0);
        tbl[3] = mk(1, 32'hF803_0040, 32'h1234_5678, 4'h3, 0, 0, 40, 2'b00, 0, 2, 1, 32'h0);
        tbl[4] = mk(1, 32'hF803_0044, 32'hA5A5_A5A5, 4'hF, 2, 0, TO - 1, 2'b00, 0, 0, 0, 32'h0);
        tbl[5] = mk(0, 32'h4000_0008, 0, 0, 2, 0, 3, 2'b01, 32'h1234_5678, 0, 0, 32'h1234_5678);
        tbl[6] = mk(1, 32'h4000_000C, 32'h0BAD_F00D, 4'h8, 1, 1, 2, 2'b11, 0, 3, 1, 32'h0);
        tbl[7] = mk(0, 32'h4000_0010, 0, 0, 0, 0, TO + 4, 2'b00, 32'h5555_AAAA, 1, 1, 32'h0);
        tbl[8] = mk(0, 32'h4000_0014, 0, 0, 0, 0, TO - 1, 2'b00, 32'hCAFE_0001, 0, 0, 32'hCAFE_0001);
        tbl[9] = mk(0, 32'h1000_0007, 0, 0, 0, 0, 0, 2'b00, 32'h0000_00FF, 0, 0, 32'h0000_00FF);

        repeat (3) @(negedge clk);
        chk("reset/handshake_outs", {25'd0, req_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
        chk("reset/rsp", {30'd0, rsp_error, bad_addr_valid}, 32'd0);
        chk("reset/rsp_rdata", rsp_rdata, 32'd0);
        chk("reset/bad_addr", bad_addr, 32'd0);
        chk("reset/addr_data", awaddr | araddr | wdata, 32'd0);
        rst = 0;
        @(negedge clk);
        chk("reset/req_ready_after", 32'(req_ready), 32'd1);

        for (int i = 0; i < 10; i++) run(tbl[i], $sformatf("vec%0d", i));

        // Reset pulse while the read address is still waiting for arready.
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 32'h2000_0000;
        for (int n = 0; n < 100 && !req_ready; n++) @(negedge clk);
        @(negedge clk);
        req_valid = 0;
        chk("rst_mid/arvalid_before", 32'(arvalid), 32'd1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_mid/outs_after", {29'd0, arvalid, rsp_valid, rready}, 32'd0);
        @(negedge clk);
        chk("rst_mid/req_ready", 32'(req_ready), 32'd1);
        chk("rst_mid/arvalid_idle", 32'(arvalid), 32'd0);

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.wr = 1'($urandom_range(0, 1));
            v.addr = $urandom; v.wdata = $urandom; v.wstrb = 4'($urandom);
            v.aw_dly = $urandom_range(0, 3); v.w_dly = $urandom_range(0, 3);
            case ($urandom_range(0, 4))
                0:       v.rsp_dly = TO - 1;
                1:       v.rsp_dly = $urandom_range(TO + 1, TO + 6);
                default: v.rsp_dly = $urandom_range(0, 4);
            endcase
            v.resp = 2'($urandom); v.rdata = $urandom; v.ack_dly = $urandom_range(0, 3);
            v = model(v);
            run(v, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
